// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants: parity modes, transmitter FSM encoding and frame-length helper.
// Imported by the transmitter top; the receiver can reuse the same encodings.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Clock cycles taken by one complete frame on the line.
  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity, input int stop_bits);
    return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side word interface plus line/status outputs of the UART transmitter.
// master = byte source / observer, slave = transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 i_TX_DV;
  logic [DATA_BITS-1:0] i_TX_Byte;
  logic                 o_TX_Ready;
  logic                 o_Overflow;
  logic [CW-1:0]        o_FIFO_Count;
  logic                 o_TX_Active;
  logic                 o_TX_Serial;
  logic                 o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_Overflow, o_FIFO_Count, o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_Overflow, o_FIFO_Count, o_TX_Active, o_TX_Serial, o_TX_Done
  );
endinterface

// File: rtl/uart_tx_fifo_fifo.sv
// Generic synchronous FIFO, show-ahead read data; full/empty/count are registered.
// Writes while full and reads while empty are ignored, so callers may strobe freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [AW:0]      count_nxt;

  // A write is refused on full even when a read frees a slot in the same cycle.
  assign wr_ok     = wr_en && !full;
  assign rd_ok     = rd_en && !empty;
  assign count_nxt = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a FIFO; line output lags the FSM by one registered cycle.
// Write to empty idle FIFO -> start bit two edges later; o_TX_Ready drops when the FIFO is full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  uart_tx_fifo_if.slave  tx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  logic [2:0]           state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 bit_end;
  logic                 frame_end;
  logic                 pop;
  logic                 line_bit;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .wr_en   (tx.i_TX_DV),
    .wr_data (tx.i_TX_Byte),
    .rd_en   (pop),
    .rd_data (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (tx.o_FIFO_Count)
  );

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
    if (PARITY == PARITY_ODD) return ~^w;
    else                      return ^w;
  endfunction

  assign bit_end   = (clk_cnt == CNT_MAX);
  assign frame_end = (state == ST_STOP) && bit_end && (stop_idx == STOP_LAST);
  // Popping on the last stop cycle chains the next start bit with no idle gap.
  assign pop       = ((state == ST_IDLE) || frame_end) && !fifo_empty;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= ST_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else if (pop) begin
      state    <= ST_START;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= fifo_dat;
      par_bit  <= calc_parity(fifo_dat);
    end else if (state != ST_IDLE) begin
      clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      if (bit_end) begin
        case (state)
          ST_START: state <= ST_DATA;
          ST_DATA: begin
            shreg <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          ST_PARITY: state <= ST_STOP;
          ST_STOP: begin
            if (stop_idx == STOP_LAST) state <= ST_IDLE;
            else                       stop_idx <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shreg[0];
      ST_PARITY: line_bit = par_bit;
      default:   line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx.o_TX_Serial <= 1'b1;
      tx.o_TX_Active <= 1'b0;
      tx.o_TX_Done   <= 1'b0;
      tx.o_Overflow  <= 1'b0;
    end else begin
      tx.o_TX_Serial <= line_bit;
      tx.o_TX_Active <= (state != ST_IDLE);
      tx.o_TX_Done   <= frame_end;
      tx.o_Overflow  <= tx.i_TX_DV && fifo_full;
    end
  end

  assign tx.o_TX_Ready = !fifo_full;
endmodule
